micro_sequencer: RTL and testbench
==================================

// Module: micro_sequencer
// PURPOSE
//  Parametrised microprogram sequencer; drives the control-store (ROM) address each cycle.
//  Successor to the fixed-table sequencer, adding:
//   - a runtime-loadable opcode dispatch map with per-entry valid bits;
//   - flag-selected conditional branches;
//   - a micro-subroutine call/return stack;
//   - halt/resume, and a trap path for illegal opcodes and stack errors.
//  Sits between IR and control-store ROM; its micro-op inputs come from the ROM output word.
// PARAMETERS
//  AW        8   control-store address width
//  OPW       8   opcode width; dispatch map holds 2**OPW entries
//  NFLAG     4   number of ALU/status flags selectable by branches
//  SDEPTH    4   call-stack depth (entries), >=1
//  TRAP_ADDR 0xFF  microaddress entered on illegal opcode or stack error
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      synchronous active-low reset
//  ir_op      in   OPW    opcode from IR
//  flags      in   NFLAG  status flags
//  uc_inc     in   1      advance to ca+1
//  uc_fetch   in   1      return to address 0 (fetch)
//  uc_disp    in   1      dispatch via map[ir_op]
//  uc_br      in   1      conditional branch to uc_tgt
//  uc_call    in   1      push ca+1, jump to uc_tgt
//  uc_ret     in   1      pop, jump to popped address
//  uc_halt    in   1      enter HALTED
//  uc_tgt     in   AW     branch/call target
//  uc_csel    in   clog2(NFLAG)  flag index for uc_br (0 when NFLAG==1)
//  uc_cinv    in   1      invert selected flag
//  resume     in   1      leave HALTED
//  map_we     in   1      dispatch-map write strobe
//  map_addr   in   OPW    map entry to write
//  map_data   in   AW     microaddress to store; entry marked valid
//  map_clr    in   1      clear all map valid bits
//  rom_addr   out  AW     current microaddress (registered ca)
//  halted     out  1      state==HALTED
//  illegal_op out  1      sticky: dispatch hit invalid entry
//  stack_err  out  1      sticky: overflow or underflow
//  sp         out  clog2(SDEPTH+1)  stack occupancy
// BEHAVIOUR
//  Reset (rst_n=0 at edge):
//   - ca=0, state=RUN, sp=0, illegal_op=0, stack_err=0, all map valid bits=0.
//   - Map data is don't-care after reset.
//  rom_addr=ca, registered; a decision on edge N is visible after edge N.
//  RUN, one action per edge, strict priority (lower ones ignored):
//   uc_halt > uc_fetch > uc_ret > uc_call > uc_disp > uc_br > uc_inc > hold.
//   - halt:  ca holds; state->HALTED.
//   - fetch: ca<=0.
//   - ret:   if sp>0, ca<=stack[sp-1], sp--;
//            else ca<=TRAP_ADDR, stack_err<=1, sp stays 0.
//   - call:  if sp<SDEPTH, stack[sp]<=ca+1, sp++, ca<=uc_tgt;
//            else ca<=TRAP_ADDR, stack_err<=1, no push.
//   - disp:  if valid[ir_op], ca<=map[ir_op];
//            else ca<=TRAP_ADDR, illegal_op<=1.
//   - br:    taken=flags[uc_csel]^uc_cinv; ca<=taken ? uc_tgt : ca+1.
//            uc_csel>=NFLAG reads flag as 0.
//   - inc:   ca<=ca+1, modulo 2**AW; 2**AW-1 wraps to 0. ca+1 for stack push wraps likewise.
//  HALTED:
//   - ca, sp, stack frozen; all uc_* ignored.
//   - resume=1 -> state RUN, ca<=ca+1 on that edge.
//  Dispatch map:
//   - map_we writes map[map_addr]<=map_data and valid<=1, in any state.
//   - map_clr clears all valid bits; same-edge map_we entry remains valid (write wins).
//   - Same-edge write and dispatch of the same opcode: dispatch uses the OLD entry.
//  Sticky flags clear only on reset; trap entry does not change state or sp.
//  Reset mid-call or in HALTED: all state discarded immediately.
// TESTING
//  - Reset, map_we op 0x03->21, ca=5, uc_disp with ir_op=0x03 -> rom_addr=21 next cycle.
//  - uc_disp with ir_op=0x20 (never mapped) -> rom_addr=0xFF, illegal_op=1; stays 1 after later fetch.
//  - flags=4'b0001, uc_br csel=0 cinv=0 tgt=47 from ca=10 -> 47; same with cinv=1 -> 11.
//  - SDEPTH=4: 4 nested calls from ca=2,30,40,50 (tgt 30,40,50,60) -> sp=4; 5th call -> 0xFF, stack_err=1;
//    after reset, repeat the 4 calls then 4 rets -> 51,41,31,3.
//  - ret with sp=0 -> 0xFF, stack_err=1; uc_halt+uc_inc same edge at ca=7 -> ca=7, halted=1;
//    uc_inc while halted -> ca=7; resume -> 8.
//  - ca=0xFF, uc_inc -> 0; rst_n=0 while halted with sp=2 -> ca=0, sp=0, halted=0, flags cleared.

Source files
------------

// File: rtl/micro_sequencer_if.sv
// Control interface between the control-store ROM word / IR / map loader and the micro
// sequencer.
//   master: drives the micro-op fields, opcode, flags, resume and map-load strobes;
//           observes rom_addr, halted, illegal_op, stack_err and sp.
//   slave:  the sequencer side (directions mirrored).
interface micro_sequencer_if #(
  parameter int unsigned AW     = 8,
  parameter int unsigned OPW    = 8,
  parameter int unsigned NFLAG  = 4,
  parameter int unsigned SDEPTH = 4
) ();
  // A single-flag build still carries a 1-bit select, which must be driven to 0.
  localparam int unsigned CSW = (NFLAG > 1) ? $clog2(NFLAG) : 1;
  localparam int unsigned SPW = $clog2(SDEPTH + 1);

  logic [OPW-1:0]   ir_op;
  logic [NFLAG-1:0] flags;
  logic             uc_inc;
  logic             uc_fetch;
  logic             uc_disp;
  logic             uc_br;
  logic             uc_call;
  logic             uc_ret;
  logic             uc_halt;
  logic [AW-1:0]    uc_tgt;
  logic [CSW-1:0]   uc_csel;
  logic             uc_cinv;
  logic             resume;
  logic             map_we;
  logic [OPW-1:0]   map_addr;
  logic [AW-1:0]    map_data;
  logic             map_clr;
  logic [AW-1:0]    rom_addr;
  logic             halted;
  logic             illegal_op;
  logic             stack_err;
  logic [SPW-1:0]   sp;

  modport master (
    output ir_op, flags, uc_inc, uc_fetch, uc_disp, uc_br, uc_call, uc_ret, uc_halt,
           uc_tgt, uc_csel, uc_cinv, resume, map_we, map_addr, map_data, map_clr,
    input  rom_addr, halted, illegal_op, stack_err, sp
  );

  modport slave (
    input  ir_op, flags, uc_inc, uc_fetch, uc_disp, uc_br, uc_call, uc_ret, uc_halt,
           uc_tgt, uc_csel, uc_cinv, resume, map_we, map_addr, map_data, map_clr,
    output rom_addr, halted, illegal_op, stack_err, sp
  );
endinterface

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: produces the registered control-store address each cycle.
// Supports increment, fetch, opcode dispatch through a runtime-loadable map with valid bits,
// flag-selected conditional branches, a call/return stack, halt/resume and a trap path.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - synchronous active-low reset
//   bus_io - micro_sequencer_if slave: micro-op inputs, map loader, status outputs
module micro_sequencer #(
  parameter int unsigned   AW        = 8,
  parameter int unsigned   OPW       = 8,
  parameter int unsigned   NFLAG     = 4,
  parameter int unsigned   SDEPTH    = 4,
  parameter logic [AW-1:0] TRAP_ADDR = '1
) (
  input logic              clk,
  input logic              rst_n,
  micro_sequencer_if.slave bus_io
);
  localparam int unsigned CSW  = (NFLAG > 1) ? $clog2(NFLAG) : 1;
  localparam int unsigned NFE  = 2 ** CSW;
  localparam int unsigned SPW  = $clog2(SDEPTH + 1);
  localparam int unsigned SIW  = (SDEPTH > 1) ? $clog2(SDEPTH) : 1;
  localparam int unsigned NMAP = 2 ** OPW;

  typedef enum logic [0:0] {StRun, StHalted} state_e;

  state_e          state_q;
  logic [AW-1:0]   ca_q;
  logic [SPW-1:0]  sp_q;
  logic            illegal_q;
  logic            stack_err_q;
  logic [NMAP-1:0] valid_q;
  logic [AW-1:0]   map_q   [NMAP];
  logic [AW-1:0]   stack_q [SDEPTH];

  logic [AW-1:0]  ca_inc;
  logic [NFE-1:0] flags_ext;
  logic           br_taken;
  logic [SIW-1:0] push_idx;
  logic [SIW-1:0] pop_idx;
  logic           can_push;
  logic           can_pop;

  assign ca_inc    = ca_q + AW'(1);
  // Zero-extend so selects beyond the last real flag read as 0.
  assign flags_ext = NFE'(bus_io.flags);
  assign br_taken  = flags_ext[bus_io.uc_csel] ^ bus_io.uc_cinv;
  assign push_idx  = SIW'(sp_q);
  assign pop_idx   = SIW'(sp_q - SPW'(1));
  assign can_push  = sp_q < SPW'(SDEPTH);
  assign can_pop   = sp_q != '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StRun;
      ca_q        <= '0;
      sp_q        <= '0;
      illegal_q   <= 1'b0;
      stack_err_q <= 1'b0;
      valid_q     <= '0;
    end else begin
      // Valid bits update in any state; a same-edge write survives a clear.
      if (bus_io.map_clr) valid_q <= '0;
      if (bus_io.map_we)  valid_q[bus_io.map_addr] <= 1'b1;

      unique case (state_q)
        StRun: begin
          if (bus_io.uc_halt) begin
            state_q <= StHalted;
          end else if (bus_io.uc_fetch) begin
            ca_q <= '0;
          end else if (bus_io.uc_ret) begin
            if (can_pop) begin
              ca_q <= stack_q[pop_idx];
              sp_q <= sp_q - SPW'(1);
            end else begin
              ca_q        <= TRAP_ADDR;
              stack_err_q <= 1'b1;
            end
          end else if (bus_io.uc_call) begin
            if (can_push) begin
              stack_q[push_idx] <= ca_inc;
              sp_q              <= sp_q + SPW'(1);
              ca_q              <= bus_io.uc_tgt;
            end else begin
              ca_q        <= TRAP_ADDR;
              stack_err_q <= 1'b1;
            end
          end else if (bus_io.uc_disp) begin
            // Reads the pre-edge map, so a same-edge reload is not yet visible.
            if (valid_q[bus_io.ir_op]) begin
              ca_q <= map_q[bus_io.ir_op];
            end else begin
              ca_q      <= TRAP_ADDR;
              illegal_q <= 1'b1;
            end
          end else if (bus_io.uc_br) begin
            ca_q <= br_taken ? bus_io.uc_tgt : ca_inc;
          end else if (bus_io.uc_inc) begin
            ca_q <= ca_inc;
          end
        end
        StHalted: begin
          if (bus_io.resume) begin
            state_q <= StRun;
            ca_q    <= ca_inc;
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

  // Map data needs no reset; the valid bits gate its use.
  always_ff @(posedge clk) begin
    if (rst_n && bus_io.map_we) map_q[bus_io.map_addr] <= bus_io.map_data;
  end

  assign bus_io.rom_addr   = ca_q;
  assign bus_io.halted     = (state_q == StHalted);
  assign bus_io.illegal_op = illegal_q;
  assign bus_io.stack_err  = stack_err_q;
  assign bus_io.sp         = sp_q;
endmodule

// File: tb/tb_micro_sequencer.sv
module tb_micro_sequencer;
  localparam int AW     = 8;
  localparam int OPW    = 8;
  localparam int NFLAG  = 4;
  localparam int SDEPTH = 4;
  localparam int TRAP   = 255;
  localparam int AMOD   = 256;

  typedef enum int {KInc, KFetch, KDisp, KBr, KBrInv, KCall, KRet, KHaltInc, KResume,
                    KMapW, KGoto} kind_e;
  typedef struct {
    string name;
    kind_e kind;
    int    a;
    int    b;
    int    fl;
    int    exp_addr;
    int    exp_sp;
    int    exp_halt;
  } vec_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  vec_t tbl[$];

  // Reference model state
  int m_ca;
  int m_halt;
  int m_ill;
  int m_serr;
  int m_stack[$];
  int m_map[AMOD];
  bit m_valid[AMOD];

  micro_sequencer_if #(.AW(AW), .OPW(OPW), .NFLAG(NFLAG), .SDEPTH(SDEPTH)) bus ();

  micro_sequencer #(.AW(AW), .OPW(OPW), .NFLAG(NFLAG), .SDEPTH(SDEPTH), .TRAP_ADDR(8'hFF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_io(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.ir_op = '0;   bus.flags = '0;    bus.uc_inc = 0;  bus.uc_fetch = 0;
    bus.uc_disp = 0;  bus.uc_br = 0;     bus.uc_call = 0; bus.uc_ret = 0;
    bus.uc_halt = 0;  bus.uc_tgt = '0;   bus.uc_csel = '0; bus.uc_cinv = 0;
    bus.resume = 0;   bus.map_we = 0;    bus.map_addr = '0; bus.map_data = '0;
    bus.map_clr = 0;
  endtask

  // Behavioural next state from the current inputs, applied at the coming edge.
  task automatic model_step();
    int nca;
    int op;
    int ci;
    bit f;
    if (!rst_n) begin
      m_ca = 0; m_halt = 0; m_ill = 0; m_serr = 0;
      m_stack.delete();
      foreach (m_valid[i]) m_valid[i] = 0;
      return;
    end
    nca = m_ca;
    if (m_halt != 0) begin
      if (bus.resume) begin
        m_halt = 0;
        nca = (m_ca + 1) % AMOD;
      end
    end else if (bus.uc_halt) begin
      m_halt = 1;
    end else if (bus.uc_fetch) begin
      nca = 0;
    end else if (bus.uc_ret) begin
      if (m_stack.size() > 0) nca = m_stack.pop_back();
      else begin nca = TRAP; m_serr = 1; end
    end else if (bus.uc_call) begin
      if (m_stack.size() < SDEPTH) begin
        m_stack.push_back((m_ca + 1) % AMOD);
        nca = int'(bus.uc_tgt);
      end else begin nca = TRAP; m_serr = 1; end
    end else if (bus.uc_disp) begin
      op = int'(bus.ir_op);
      if (m_valid[op]) nca = m_map[op];
      else begin nca = TRAP; m_ill = 1; end
    end else if (bus.uc_br) begin
      ci = int'(bus.uc_csel);
      f = (ci < NFLAG) ? bus.flags[ci] : 1'b0;
      nca = (f ^ bus.uc_cinv) ? int'(bus.uc_tgt) : (m_ca + 1) % AMOD;
    end else if (bus.uc_inc) begin
      nca = (m_ca + 1) % AMOD;
    end
    m_ca = nca;
    if (bus.map_clr) foreach (m_valid[i]) m_valid[i] = 0;
    if (bus.map_we) begin
      m_valid[int'(bus.map_addr)] = 1;
      m_map[int'(bus.map_addr)] = int'(bus.map_data);
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".addr"},   32'(bus.rom_addr),   32'(m_ca));
    check({tag, ".sp"},     32'(bus.sp),         32'(m_stack.size()));
    check({tag, ".halted"}, 32'(bus.halted),     32'(m_halt));
    check({tag, ".ill"},    32'(bus.illegal_op), 32'(m_ill));
    check({tag, ".serr"},   32'(bus.stack_err),  32'(m_serr));
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  // Branch forced taken: a direct way to place ca.
  task automatic set_goto(input int a);
    bus.uc_br = 1; bus.flags = 4'b0001; bus.uc_csel = '0; bus.uc_cinv = 0;
    bus.uc_tgt = AW'(a);
  endtask

  task automatic apply_vec(input vec_t v);
    clear_inputs();
    case (v.kind)
      KInc:     bus.uc_inc = 1;
      KFetch:   bus.uc_fetch = 1;
      KDisp:    begin bus.uc_disp = 1; bus.ir_op = OPW'(v.a); end
      KBr, KBrInv: begin
        bus.uc_br = 1; bus.uc_tgt = AW'(v.a); bus.uc_csel = 2'(v.b);
        bus.flags = 4'(v.fl); bus.uc_cinv = (v.kind == KBrInv);
      end
      KCall:    begin bus.uc_call = 1; bus.uc_tgt = AW'(v.a); end
      KRet:     bus.uc_ret = 1;
      KHaltInc: begin bus.uc_halt = 1; bus.uc_inc = 1; end
      KResume:  bus.resume = 1;
      KMapW:    begin bus.map_we = 1; bus.map_addr = OPW'(v.a); bus.map_data = AW'(v.b); end
      KGoto:    set_goto(v.a);
      default:  ;
    endcase
    cycle();
    check({v.name, ".addr"},   32'(bus.rom_addr), 32'(v.exp_addr));
    check({v.name, ".sp"},     32'(bus.sp),       32'(v.exp_sp));
    check({v.name, ".halted"}, 32'(bus.halted),   32'(v.exp_halt));
  endtask

  function automatic void add(string n, kind_e k, int a, int b, int fl, int ea, int es, int eh);
    vec_t v;
    v.name = n; v.kind = k; v.a = a; v.b = b; v.fl = fl;
    v.exp_addr = ea; v.exp_sp = es; v.exp_halt = eh;
    tbl.push_back(v);
  endfunction

  initial begin
    errors = 0;
    checks = 0;
    m_ca = 0; m_halt = 0; m_ill = 0; m_serr = 0;
    rst_n = 1'b0;
    clear_inputs();

    add("mapw3",     KMapW,   3, 21, 0,  0, 0, 0);
    add("goto5",     KGoto,   5, 0,  0,  5, 0, 0);
    add("disp3",     KDisp,   3, 0,  0, 21, 0, 0);
    add("disp20",    KDisp, 'h20, 0, 0, TRAP, 0, 0);
    add("fetch",     KFetch,  0, 0,  0,  0, 0, 0);
    add("goto10",    KGoto,  10, 0,  0, 10, 0, 0);
    add("br_taken",  KBr,    47, 0,  1, 47, 0, 0);
    add("goto10b",   KGoto,  10, 0,  0, 10, 0, 0);
    add("br_inv",    KBrInv, 47, 0,  1, 11, 0, 0);
    add("br_nt",     KBr,    47, 0,  0, 12, 0, 0);
    add("br_csel3",  KBr,    90, 3,  8, 90, 0, 0);
    add("br_inv0",   KBrInv, 60, 0,  0, 60, 0, 0);
    add("goto2",     KGoto,   2, 0,  0,  2, 0, 0);
    add("call30",    KCall,  30, 0,  0, 30, 1, 0);
    add("call40",    KCall,  40, 0,  0, 40, 2, 0);
    add("call50",    KCall,  50, 0,  0, 50, 3, 0);
    add("call60",    KCall,  60, 0,  0, 60, 4, 0);
    add("call_ovf",  KCall,  70, 0,  0, TRAP, 4, 0);
    add("ret1",      KRet,    0, 0,  0, 51, 3, 0);
    add("ret2",      KRet,    0, 0,  0, 41, 2, 0);
    add("ret3",      KRet,    0, 0,  0, 31, 1, 0);
    add("ret4",      KRet,    0, 0,  0,  3, 0, 0);
    add("ret_unf",   KRet,    0, 0,  0, TRAP, 0, 0);
    add("goto7",     KGoto,   7, 0,  0,  7, 0, 0);
    add("halt_inc",  KHaltInc, 0, 0, 0,  7, 0, 1);
    add("inc_halt",  KInc,    0, 0,  0,  7, 0, 1);
    add("resume",    KResume, 0, 0,  0,  8, 0, 0);
    add("gotoFF",    KGoto, 255, 0,  0, 255, 0, 0);
    add("inc_wrap",  KInc,    0, 0,  0,  0, 0, 0);
    add("gotoFF2",   KGoto, 255, 0,  0, 255, 0, 0);
    add("call_wrap", KCall,  16, 0,  0, 16, 1, 0);
    add("ret_wrap",  KRet,    0, 0,  0,  0, 0, 0);

    do_reset();
    do_reset();
    check_model("reset");
    check("reset.addr0", 32'(bus.rom_addr), 32'd0);

    foreach (tbl[i]) apply_vec(tbl[i]);
    check("sticky.ill",  32'(bus.illegal_op), 32'd1);
    check("sticky.serr", 32'(bus.stack_err),  32'd1);

    // Clear and write on the same edge: the written entry stays valid.
    do_reset();
    clear_inputs(); bus.map_we = 1; bus.map_addr = 8'h06; bus.map_data = 8'h44; cycle();
    clear_inputs(); bus.map_clr = 1; bus.map_we = 1; bus.map_addr = 8'h05;
    bus.map_data = 8'h33; cycle();
    clear_inputs(); bus.uc_disp = 1; bus.ir_op = 8'h05; cycle();
    check("clrwe.keep", 32'(bus.rom_addr), 32'h33);
    clear_inputs(); bus.uc_disp = 1; bus.ir_op = 8'h06; cycle();
    check("clrwe.gone", 32'(bus.rom_addr), 32'hFF);
    check("clrwe.ill",  32'(bus.illegal_op), 32'd1);

    // Dispatch on the edge that rewrites its entry uses the old entry.
    do_reset();
    clear_inputs(); bus.map_we = 1; bus.map_addr = 8'h07; bus.map_data = 8'h10; cycle();
    clear_inputs(); bus.uc_disp = 1; bus.ir_op = 8'h07;
    bus.map_we = 1; bus.map_addr = 8'h07; bus.map_data = 8'h20; cycle();
    check("wdisp.old", 32'(bus.rom_addr), 32'h10);
    clear_inputs(); bus.uc_disp = 1; bus.ir_op = 8'h07; cycle();
    check("wdisp.new", 32'(bus.rom_addr), 32'h20);

    // Map load while halted, then reset while halted with a loaded stack.
    do_reset();
    clear_inputs(); bus.uc_halt = 1; cycle();
    clear_inputs(); bus.map_we = 1; bus.map_addr = 8'h08; bus.map_data = 8'h55;
    bus.uc_call = 1; bus.uc_tgt = 8'h40; cycle();
    check("hmap.addr", 32'(bus.rom_addr), 32'd0);
    check("hmap.sp",   32'(bus.sp),       32'd0);
    clear_inputs(); bus.resume = 1; cycle();
    check("hmap.res",  32'(bus.rom_addr), 32'd1);
    clear_inputs(); bus.uc_disp = 1; bus.ir_op = 8'h08; cycle();
    check("hmap.disp", 32'(bus.rom_addr), 32'h55);
    clear_inputs(); bus.uc_call = 1; bus.uc_tgt = 8'h20; cycle();
    clear_inputs(); bus.uc_call = 1; bus.uc_tgt = 8'h30; cycle();
    clear_inputs(); bus.uc_disp = 1; bus.ir_op = 8'h99; cycle();
    clear_inputs(); bus.uc_halt = 1; cycle();
    check("hrst.pre_sp",  32'(bus.sp),     32'd2);
    check("hrst.pre_hlt", 32'(bus.halted), 32'd1);
    do_reset();
    check_model("hrst");
    check("hrst.ill0", 32'(bus.illegal_op), 32'd0);

    // Randomised run against the reference model.
    for (int i = 0; i < 3000; i++) begin
      clear_inputs();
      rst_n        = ($urandom_range(0, 299) != 0);
      bus.uc_halt  = ($urandom_range(0, 15) == 0);
      bus.uc_fetch = ($urandom_range(0, 9) == 0);
      bus.uc_ret   = ($urandom_range(0, 4) == 0);
      bus.uc_call  = ($urandom_range(0, 4) == 0);
      bus.uc_disp  = ($urandom_range(0, 3) == 0);
      bus.uc_br    = ($urandom_range(0, 2) == 0);
      bus.uc_inc   = ($urandom_range(0, 1) == 1);
      bus.resume   = ($urandom_range(0, 2) == 0);
      bus.uc_cinv  = ($urandom_range(0, 1) == 1);
      bus.ir_op    = OPW'($urandom_range(0, 15));
      bus.flags    = 4'($urandom);
      bus.uc_csel  = 2'($urandom);
      bus.uc_tgt   = AW'($urandom);
      bus.map_we   = ($urandom_range(0, 3) == 0);
      bus.map_addr = OPW'($urandom_range(0, 15));
      bus.map_data = AW'($urandom);
      bus.map_clr  = ($urandom_range(0, 63) == 0);
      cycle();
      check_model("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
